idct_pixel_collector: RTL and testbench

Synthesizable sink for the IDCT output stream. Captures each 64-sample `done`-framed burst from the IDCT, extracts the 8-bit pixel field, and buffers blocks in a two-bank ping-pong store. Re-emits pixels on a valid/ready stream toward the frame writer. It replaces the simulation-only capture path with hardware, so reconstructed 8x8 blocks can leave the chip in raster order within each block.

---
 rtl/idct_pixel_collector_if.sv | 28 ++
 rtl/idct_pixel_collector.sv | 233 +++++++++++++++++++++++
 tb/tb_idct_pixel_collector.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idct_pixel_collector_if.sv
// idct_pixel_collector_if
// Bundles the IDCT capture side (done_in/din), the valid/ready pixel stream
// toward the frame writer, and the collector's status outputs.
//   master : IDCT source + frame writer side (drives done_in, din, out_ready)
//   slave  : the collector itself
interface idct_pixel_collector_if #(
    parameter int DW = 32
);
    logic          done_in;
    logic [DW-1:0] din;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_pix;
    logic          out_last;
    logic [15:0]   blk_count;
    logic          ovf;
    logic          short_err;

    modport master (
        output done_in, din, out_ready,
        input  out_valid, out_pix, out_last, blk_count, ovf, short_err
    );

    modport slave (
        input  done_in, din, out_ready,
        output out_valid, out_pix, out_last, blk_count, ovf, short_err
    );
endinterface

// File: rtl/idct_pixel_collector.sv
// idct_pixel_collector
// Hardware sink for the IDCT output stream. Each done_in-framed burst of BLK
// samples is reduced to 8-bit pixels and written into one bank of a two-bank
// ping-pong store; full banks are replayed in address order on a valid/ready
// stream. A burst arriving while both banks are occupied is dropped (sticky
// ovf); a burst that ends early is discarded (sticky short_err).
//
// Optional feature macro: PIX_SAT_EN
//   defined   : pixel saturates (negative sample -> 0, overflow above the
//               field -> 255)
//   undefined : plain truncation of din[PIX_LSB+7:PIX_LSB]
module idct_pixel_collector #(
    parameter int DW      = 32,
    parameter int PIX_LSB = 10,
    parameter int BLK     = 64
) (
    input logic                   clk,
    input logic                   reset,
    idct_pixel_collector_if.slave bus
);

    localparam int            AW        = $clog2(BLK);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BLK - 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rd_state_t;

    wr_state_t     wr_state;
    rd_state_t     rd_state;

    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic [AW-1:0] rcnt_next;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    bank_full;

    logic [7:0]    mem [0:2*BLK-1];

    logic [7:0]    pix_in;
    logic          hs;
    logic          last_hs;
    logic          wr_free;
    logic          start_fill;
    logic          fill_done;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [AW:0]   rd_addr;

    logic          out_valid_r;
    logic [7:0]    out_pix_r;
    logic          out_last_r;
    logic [15:0]   blk_count_r;
    logic          ovf_r;
    logic          short_err_r;

`ifdef PIX_SAT_EN
    // Saturating pixel extraction: sign bit clamps to black, any magnitude
    // above the pixel field clamps to white.
    always_comb begin
        if (bus.din[DW-1]) begin
            pix_in = 8'h00;
        end else if (|(bus.din[DW-2:0] >> (PIX_LSB + 8))) begin
            pix_in = 8'hFF;
        end else begin
            pix_in = 8'(bus.din >> PIX_LSB);
        end
    end
`else
    // Truncating pixel extraction, bit-exact with the legacy capture path.
    assign pix_in = 8'(bus.din >> PIX_LSB);
`endif

    assign rcnt_next = rcnt + AW'(1);

    // Handshake strobes and bank bookkeeping shared by both FSMs. A bank whose
    // last pixel leaves this very cycle already counts as free for a new burst.
    always_comb begin
        hs         = (rd_state == R_STREAM) && out_valid_r && bus.out_ready;
        last_hs    = hs && (rcnt == LAST_ADDR);
        wr_free    = !bank_full[wr_bank] || (last_hs && (rd_bank == wr_bank));
        start_fill = (wr_state == W_IDLE) && bus.done_in && wr_free;
        fill_done  = (wr_state == W_FILL) && bus.done_in && (wcnt == LAST_ADDR);
        wr_en      = start_fill || ((wr_state == W_FILL) && bus.done_in);
        wr_addr    = {wr_bank, wcnt};
    end

    // Address of the pixel to present next: the next word of the current
    // bank, or word 0 of the other bank when a block just completed.
    always_comb begin
        rd_addr = {rd_bank, {AW{1'b0}}};
        if (hs) begin
            if (rcnt != LAST_ADDR) begin
                rd_addr = {rd_bank, rcnt_next};
            end else begin
                rd_addr = {~rd_bank, {AW{1'b0}}};
            end
        end
    end

    // Pixel store: plain write port, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= pix_in;
        end
    end

    // Bank full flags: set by the write side on the 64th capture, cleared by
    // the read side on the last handshake. The two never target one bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full <= 2'b00;
        end else begin
            if (fill_done) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (last_hs) begin
                bank_full[rd_bank] <= 1'b0;
            end
        end
    end

    // Write FSM: frames bursts, fills one bank, drops excess and orphan samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state    <= W_IDLE;
            wcnt        <= '0;
            wr_bank     <= 1'b0;
            ovf_r       <= 1'b0;
            short_err_r <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (bus.done_in) begin
                        if (wr_free) begin
                            wcnt     <= AW'(1);
                            wr_state <= W_FILL;
                        end else begin
                            ovf_r    <= 1'b1;
                            wr_state <= W_DROP;
                        end
                    end
                end
                W_FILL: begin
                    if (!bus.done_in) begin
                        wcnt        <= '0;
                        short_err_r <= 1'b1;
                        wr_state    <= W_IDLE;
                    end else if (wcnt == LAST_ADDR) begin
                        wcnt     <= '0;
                        wr_bank  <= ~wr_bank;
                        wr_state <= W_DROP;
                    end else begin
                        wcnt <= wcnt + AW'(1);
                    end
                end
                W_DROP: begin
                    if (!bus.done_in) begin
                        wr_state <= W_IDLE;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: presents one pixel per handshake, chains directly into the
    // other bank when it is already full, and counts completed blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state    <= R_IDLE;
            rcnt        <= '0;
            rd_bank     <= 1'b0;
            out_valid_r <= 1'b0;
            out_pix_r   <= 8'h00;
            out_last_r  <= 1'b0;
            blk_count_r <= 16'h0000;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        out_pix_r   <= mem[rd_addr];
                        out_valid_r <= 1'b1;
                        out_last_r  <= (LAST_ADDR == '0);
                        rcnt        <= '0;
                        rd_state    <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (hs) begin
                        if (rcnt != LAST_ADDR) begin
                            rcnt       <= rcnt_next;
                            out_pix_r  <= mem[rd_addr];
                            out_last_r <= (rcnt_next == LAST_ADDR);
                        end else begin
                            rcnt        <= '0;
                            rd_bank     <= ~rd_bank;
                            blk_count_r <= blk_count_r + 16'd1;
                            out_last_r  <= 1'b0;
                            if (bank_full[~rd_bank]) begin
                                out_pix_r <= mem[rd_addr];
                            end else begin
                                out_valid_r <= 1'b0;
                                rd_state    <= R_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_pix   = out_pix_r;
    assign bus.out_last  = out_last_r;
    assign bus.blk_count = blk_count_r;
    assign bus.ovf       = ovf_r;
    assign bus.short_err = short_err_r;

endmodule

// File: tb/tb_idct_pixel_collector.sv
// tb_idct_pixel_collector
// Drives done_in-framed bursts into idct_pixel_collector and checks the pixel
// stream and status flags against a block-level reference model: a queue of
// expected pixels plus a count of blocks held in the two-bank store.
// Honours PIX_SAT_EN in the same way as the design.
module tb_idct_pixel_collector;

    localparam int DW      = 32;
    localparam int PIX_LSB = 10;
    localparam int BLK     = 64;

`ifdef PIX_SAT_EN
    localparam logic [7:0] SAT_NEG_PIX  = 8'd0;
    localparam logic [7:0] SAT_HIGH_PIX = 8'd255;
`else
    localparam logic [7:0] SAT_NEG_PIX  = 8'd255;
    localparam logic [7:0] SAT_HIGH_PIX = 8'd0;
`endif

    logic clk = 1'b0;
    logic reset;

    idct_pixel_collector_if #(.DW(DW)) bus ();

    idct_pixel_collector #(
        .DW      (DW),
        .PIX_LSB (PIX_LSB),
        .BLK     (BLK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total_checks = 0;
    int          bad_checks   = 0;

    logic [7:0]  exp_pix_q[$];
    bit          exp_last_q[$];
    int          accepted_blocks = 0;
    int          emitted_blocks  = 0;
    int          hs_total        = 0;
    bit          exp_ovf         = 1'b0;
    bit          exp_short       = 1'b0;
    int          ready_mode      = 0;
    bit          prev_stall      = 1'b0;
    logic [DW-1:0] burst_data [0:127];

    // Reference pixel rule written as plain arithmetic on the sample value.
    function automatic logic [7:0] refPixel(input logic [DW-1:0] s);
        longint mag;
`ifdef PIX_SAT_EN
        longint val;
`endif
        mag = longint'(s);
`ifdef PIX_SAT_EN
        val = s[DW-1] ? (mag - (longint'(1) << DW)) : mag;
        if (val < 0) return 8'd0;
        if (val >= (longint'(1) << (PIX_LSB + 8))) return 8'd255;
        return 8'(val >> PIX_LSB);
`else
        return 8'((mag >> PIX_LSB) % 256);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        if (obs !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // out_ready is owned by this process alone; mode 0 low, 1 high, 2 random.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Stream monitor: every presented pixel must match the model head; a
    // handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("valid_held_under_stall", 32'(bus.out_valid), 32'd1);
            end
            if (bus.out_valid === 1'b1) begin
                if (exp_pix_q.size() == 0) begin
                    checkOutput("valid_without_block", 32'(bus.out_valid), 32'd0);
                end else begin
                    checkOutput("out_pix", 32'(bus.out_pix), 32'(exp_pix_q[0]));
                    checkOutput("out_last", 32'(bus.out_last), 32'(exp_last_q[0]));
                    if (bus.out_ready === 1'b1) begin
                        hs_total++;
                        if (exp_last_q[0]) emitted_blocks++;
                        void'(exp_pix_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end else if (bus.out_valid !== 1'b0) begin
                checkOutput("out_valid_known", 32'(bus.out_valid), 32'd0);
            end
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        end
    end

    task automatic fillRandom();
        for (int i = 0; i < 128; i++) burst_data[i] = $urandom;
    endtask

    task automatic fillRamp();
        for (int i = 0; i < 128; i++) burst_data[i] = DW'(i) << PIX_LSB;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.done_in = 1'b0;
            bus.din     = $urandom;
        end
    endtask

    // One done_in burst of len samples. At the first sample the model decides
    // whether a bank is free: fewer than two blocks held, where a block whose
    // last pixel leaves on this same edge no longer counts.
    task automatic applyStimulus(input int len);
        int occ;
        @(posedge clk); #1;
        bus.done_in = 1'b1;
        bus.din     = burst_data[0];
        @(negedge clk); #1;
        occ = accepted_blocks - emitted_blocks;
        if (occ < 2) begin
            if (len >= BLK) begin
                for (int i = 0; i < BLK; i++) begin
                    exp_pix_q.push_back(refPixel(burst_data[i]));
                    exp_last_q.push_back(i == BLK - 1);
                end
                accepted_blocks++;
            end else begin
                exp_short = 1'b1;
            end
        end else begin
            exp_ovf = 1'b1;
        end
        for (int i = 1; i < len; i++) begin
            @(posedge clk); #1;
            bus.din = burst_data[i];
        end
        @(posedge clk); #1;
        bus.done_in = 1'b0;
        bus.din     = $urandom;
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_pix_q.delete();
        exp_last_q.delete();
        accepted_blocks = 0;
        emitted_blocks  = 0;
        exp_ovf         = 1'b0;
        exp_short       = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_out_pix"},   32'(bus.out_pix),   32'd0);
        checkOutput({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        checkOutput({tag, "_blk_count"}, 32'(bus.blk_count), 32'd0);
        checkOutput({tag, "_ovf"},       32'(bus.ovf),       32'd0);
        checkOutput({tag, "_short_err"}, 32'(bus.short_err), 32'd0);
    endtask

    task automatic waitDrain(input string tag, input int max_cycles);
        int n = 0;
        while (exp_pix_q.size() != 0 && n < max_cycles) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput({tag, "_drain"}, 32'(exp_pix_q.size()), 32'd0);
    endtask

    task automatic checkFlags(input string tag);
        @(negedge clk); #1;
        checkOutput({tag, "_blk_count"}, 32'(bus.blk_count), 32'(16'(emitted_blocks)));
        checkOutput({tag, "_ovf"},       32'(bus.ovf),       32'(exp_ovf));
        checkOutput({tag, "_short_err"}, 32'(bus.short_err), 32'(exp_short));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int n;

        reset       = 1'b1;
        bus.done_in = 1'b0;
        bus.din     = '0;
        ready_mode  = 0;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkResetValues("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic block: ramp data, latency of one edge after the 64th capture.
        $display("[TB] basic block");
        ready_mode = 1;
        fillRamp();
        applyStimulus(64);
        @(negedge clk);
        checkOutput("latency_not_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("latency_pix0", 32'(bus.out_pix), 32'd0);
        waitDrain("basic", 200);
        checkFlags("basic");

        // Backpressure: two blocks buffered, third dropped, then no bubble.
        $display("[TB] backpressure");
        applyReset();
        ready_mode = 0;
        for (int b = 0; b < 3; b++) begin
            fillRandom();
            applyStimulus(64);
        end
        idleCycles(100);
        @(negedge clk); #1;
        checkOutput("bp_ovf", 32'(bus.ovf), 32'd1);
        checkOutput("bp_valid_stalled", 32'(bus.out_valid), 32'd1);
        base = hs_total;
        @(posedge clk); #1;
        ready_mode = 1;
        repeat (128) begin
            @(negedge clk); #1;
        end
        checkOutput("bp_no_bubble", 32'(hs_total - base), 32'd128);
        waitDrain("bp", 50);
        checkFlags("bp");

        // Short burst followed by a full one.
        $display("[TB] short burst");
        applyReset();
        ready_mode = 1;
        fillRandom();
        applyStimulus(40);
        fillRandom();
        applyStimulus(64);
        waitDrain("short", 200);
        checkFlags("short");

        // Long burst: samples beyond the block are ignored.
        $display("[TB] long burst");
        applyReset();
        fillRandom();
        applyStimulus(80);
        waitDrain("long", 200);
        idleCycles(20);
        checkFlags("long");

        // Saturation corner samples in pixel positions 0 and 1.
        $display("[TB] saturation");
        applyReset();
        fillRandom();
        burst_data[0] = 32'hFFFF_FC00;
        burst_data[1] = 32'h0004_0000;
        applyStimulus(64);
        @(negedge clk);
        @(negedge clk);
        checkOutput("sat_pix0", 32'(bus.out_pix), 32'(SAT_NEG_PIX));
        @(negedge clk);
        checkOutput("sat_pix1", 32'(bus.out_pix), 32'(SAT_HIGH_PIX));
        waitDrain("sat", 200);
        checkFlags("sat");

        // Reset at pixel 20, then a fresh burst.
        $display("[TB] reset mid-stream");
        applyReset();
        fillRandom();
        applyStimulus(64);
        base = hs_total;
        n = 0;
        while ((hs_total - base) < 20 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("rst_reached_pix20", 32'(hs_total - base), 32'd20);
        applyReset();
        @(negedge clk); #1;
        checkResetValues("rst_mid");
        idleCycles(80);
        checkOutput("rst_no_residual", 32'(hs_total - base), 32'd20);
        fillRandom();
        applyStimulus(64);
        waitDrain("rst_after", 200);
        checkFlags("rst_after");

        // Sustained rate: back-to-back bursts with ready high never drop.
        $display("[TB] sustained rate");
        applyReset();
        for (int b = 0; b < 5; b++) begin
            fillRandom();
            applyStimulus(64);
        end
        waitDrain("sustain", 400);
        checkFlags("sustain");
        checkOutput("sustain_no_ovf", 32'(bus.ovf), 32'd0);

        // Randomized bursts, lengths and backpressure.
        $display("[TB] random traffic");
        applyReset();
        ready_mode = 2;
        for (int b = 0; b < 16; b++) begin
            int pick;
            int len;
            pick = $urandom_range(0, 9);
            if (pick < 6)      len = 64;
            else if (pick < 8) len = $urandom_range(65, 80);
            else               len = $urandom_range(10, 63);
            fillRandom();
            applyStimulus(len);
            idleCycles($urandom_range(0, 3));
        end
        ready_mode = 1;
        waitDrain("random", 2000);
        checkFlags("random");

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
